// File: rtl/i2s_adc_capture_if.sv
// Consumer-side bundle of the I2S capture block: show-ahead FIFO pop port plus status.
// master = capture block (producer), slave = downstream consumer.
interface i2s_adc_capture_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_AW    = 3
);
   logic                  fifo_read;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_readdata;
   logic [FIFO_AW:0]      fifo_level;
   logic                  overflow;
   logic                  frame_err;

   modport master (
      input  fifo_read,
      output fifo_empty, fifo_readdata, fifo_level, overflow, frame_err
   );

   modport slave (
      output fifo_read,
      input  fifo_empty, fifo_readdata, fifo_level, overflow, frame_err
   );
endinterface

// File: rtl/i2s_adc_capture.sv
// I2S ADC front end: oversampled BCLK/ADCLRC/ADCDAT, stereo frame deserialiser, show-ahead FIFO.
// state  | meaning
// SYNC   | waiting for a left-channel start (ADCLRC 1->0)
// L_DLY  | one-bit I2S delay slot before the left MSB
// L_DATA | shifting left sample, holds once SAMPLE_BITS captured
// R_DLY  | one-bit I2S delay slot before the right MSB
// R_DATA | shifting right sample, pushes {L,R} on its last bit
module i2s_adc_capture #(
   parameter int DATA_WIDTH  = 32,
   parameter int SAMPLE_BITS = 16,
   parameter int FIFO_AW     = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               bclk,
   input  logic               adclrc,
   input  logic               adcdat,
   i2s_adc_capture_if.master  fifo_bus
);
   localparam int DEPTH = 2**FIFO_AW;
   localparam int CW    = $clog2(SAMPLE_BITS + 1);
   localparam logic [CW-1:0]      BC_FULL = CW'(SAMPLE_BITS);
   localparam logic [CW-1:0]      BC_LAST = CW'(SAMPLE_BITS - 1);
   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);

   typedef enum logic [2:0] {SYNC, L_DLY, L_DATA, R_DLY, R_DATA} state_t;

   logic [2:0] bclk_sync_q;
   logic [1:0] lrc_sync_q, dat_sync_q;
   logic       bclk_rise, lrc_s, dat_s, lrc_chg;

   state_t                 state_q, state_d;
   logic [CW-1:0]          bitcnt_q, bitcnt_d;
   logic [SAMPLE_BITS-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
   logic                   l_ok_q, l_ok_d;
   logic                   lrc_prev_q, lrc_prev_d;
   logic                   push_q, push_d;
   logic                   frame_err_q, frame_err_d;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
   logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]       level_q, level_d;
   logic                   ovf_q, ovf_d;
   logic                   fifo_full, fifo_emp, do_push, do_pop;

   // bclk gets a third stage so the rising edge stays aligned with synced lrc/dat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_sync_q <= '0;
         lrc_sync_q  <= '0;
         dat_sync_q  <= '0;
      end else begin
         bclk_sync_q <= {bclk_sync_q[1:0], bclk};
         lrc_sync_q  <= {lrc_sync_q[0], adclrc};
         dat_sync_q  <= {dat_sync_q[0], adcdat};
      end
   end

   assign bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
   assign lrc_s     = lrc_sync_q[1];
   assign dat_s     = dat_sync_q[1];
   assign lrc_chg   = lrc_s ^ lrc_prev_q;

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      sh_l_d      = sh_l_q;
      sh_r_d      = sh_r_q;
      l_ok_d      = l_ok_q;
      lrc_prev_d  = lrc_prev_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
      if (bclk_rise) begin
         lrc_prev_d = lrc_s;
         case (state_q)
            SYNC: if (lrc_chg && !lrc_s) state_d = L_DLY;
            L_DLY: begin
               state_d  = L_DATA;
               bitcnt_d = '0;
            end
            L_DATA: begin
               if (lrc_chg) begin
                  state_d     = R_DLY;
                  l_ok_d      = (bitcnt_q == BC_FULL);
                  frame_err_d = (bitcnt_q != BC_FULL);
               end else if (bitcnt_q != BC_FULL) begin
                  sh_l_d   = {sh_l_q[SAMPLE_BITS-2:0], dat_s};
                  bitcnt_d = bitcnt_q + CW'(1);
               end
            end
            R_DLY: begin
               state_d  = R_DATA;
               bitcnt_d = '0;
            end
            R_DATA: begin
               if (lrc_chg) begin
                  state_d     = L_DLY;
                  frame_err_d = (bitcnt_q != BC_FULL);
               end else if (bitcnt_q != BC_FULL) begin
                  sh_r_d   = {sh_r_q[SAMPLE_BITS-2:0], dat_s};
                  bitcnt_d = bitcnt_q + CW'(1);
                  push_d   = (bitcnt_q == BC_LAST) && l_ok_q;
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   // sh_l/sh_r cannot move again until the next bclk_rise, so push_q can write them directly
   assign fifo_full = (level_q == LVL_FULL);
   assign fifo_emp  = (level_q == '0);
   assign do_pop    = fifo_bus.fifo_read && !fifo_emp;
   assign do_push   = push_q && (!fifo_full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = {sh_l_q, sh_r_q};
         wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push_q && fifo_full && !do_pop) ovf_d = 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
         2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SYNC;
         bitcnt_q    <= '0;
         sh_l_q      <= '0;
         sh_r_q      <= '0;
         l_ok_q      <= 1'b0;
         lrc_prev_q  <= 1'b0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         sh_l_q      <= sh_l_d;
         sh_r_q      <= sh_r_d;
         l_ok_q      <= l_ok_d;
         lrc_prev_q  <= lrc_prev_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         ovf_q       <= ovf_d;
      end
   end

   assign fifo_bus.fifo_empty    = fifo_emp;
   assign fifo_bus.fifo_readdata = mem_q[rd_ptr_q];
   assign fifo_bus.fifo_level    = level_q;
   assign fifo_bus.overflow      = ovf_q;
   assign fifo_bus.frame_err     = frame_err_q;
endmodule

// File: tb/tb_i2s_adc_capture.sv
// Randomised I2S frame stimulus with a queue-based reference FIFO; a negedge monitor checks every pop.
module tb_i2s_adc_capture;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic bclk = 1'b0;
   logic adclrc = 1'b1;
   logic adcdat = 1'b0;

   i2s_adc_capture_if bus ();

   i2s_adc_capture dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bclk     (bclk),
      .adclrc   (adclrc),
      .adcdat   (adcdat),
      .fifo_bus (bus.master)
   );

   always #5 clk = ~clk;

   logic [31:0] exp_q [$];
   int exp_ovf = 0;
   int exp_err = 0;
   int err_seen = 0;
   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
   endtask

   // Monitor: every DUT pop is compared against the head of the reference queue
   always @(negedge clk) begin
      if (reset_n && bus.frame_err === 1'b1) err_seen++;
      if (reset_n && bus.fifo_read && bus.fifo_empty === 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pop_unexpected actual=%h required=no_data t=%0t", bus.fifo_readdata, $time);
         end else begin
            chk("pop_data", bus.fifo_readdata, exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_empty", {31'd0, bus.fifo_empty}, 32'd1);
      chk("rst_level", {28'd0, bus.fifo_level}, 32'd0);
      chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
      chk("rst_data", bus.fifo_readdata, 32'd0);
      exp_q.delete();
      exp_ovf = 0;
      reset_n = 1'b1;
   endtask

   // One BCLK period (16 clk). mode 1: pop in the clk the push lands; mode 2: measure push latency
   task automatic bit_cycle(input logic lrc, input logic dat, input int mode);
      int  n;
      bit  seen;
      logic [31:0] lvl;
      bclk = 1'b0;
      adclrc = lrc;
      adcdat = dat;
      repeat (8) @(posedge clk);
      #1;
      bclk = 1'b1;
      if (mode == 1) begin
         repeat (3) @(posedge clk);
         #1 bus.fifo_read = 1'b1;
         @(posedge clk);
         #1 bus.fifo_read = 1'b0;
         repeat (4) @(posedge clk);
         #1;
      end else if (mode == 2) begin
         n = 0;
         seen = 1'b0;
         lvl = '0;
         for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (!seen && bus.fifo_empty === 1'b0) begin
               seen = 1'b1;
               n = i;
               lvl = {28'd0, bus.fifo_level};
            end
         end
         chk("latency_le5", {31'd0, (seen && n <= 5)}, 32'd1);
         chk("level_on_arrival", lvl, 32'd1);
      end else begin
         repeat (8) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      for (int k = 0; k < 4; k++) bit_cycle(1'b1, 1'b0, 0);
   endtask

   // Left window then right window; data bit i sits on the (i+2)th rise of its window
   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits,
                             input int mode, input bit discard);
      int nl;
      logic d;
      nl = (lbits < 16) ? lbits + 2 : 32;
      for (int k = 0; k < nl; k++) begin
         d = (k >= 2 && k - 2 < lbits) ? l[15-(k-2)] : 1'($urandom_range(0, 1));
         bit_cycle(1'b0, d, 0);
      end
      if (!discard && lbits < 16) exp_err++;
      for (int k = 0; k < 32; k++) begin
         d = (k >= 2 && k < 18) ? r[15-(k-2)] : 1'($urandom_range(0, 1));
         if (k == 17 && !discard && lbits >= 16) begin
            if (exp_q.size() < 8 || mode == 1) exp_q.push_back({l, r});
            else exp_ovf = 1;
         end
         bit_cycle(1'b1, d, (k == 17) ? mode : 0);
      end
   endtask

   task automatic read_n(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1 bus.fifo_read = 1'b1;
         @(posedge clk);
         #1 bus.fifo_read = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_level"}, {28'd0, bus.fifo_level}, 32'(exp_q.size()));
      chk({tag, "_empty"}, {31'd0, bus.fifo_empty}, {31'd0, (exp_q.size() == 0)});
      chk({tag, "_ovf"}, {31'd0, bus.overflow}, 32'(exp_ovf));
      chk({tag, "_ferr_cnt"}, 32'(err_seen), 32'(exp_err));
   endtask

   initial begin
      bus.fifo_read = 1'b0;
      do_reset();
      idle();

      // reset part-way through a left channel: that frame must never appear
      fork
         send_frame(16'hDEAD, 16'hBEEF, 16, 0, 1'b1);
         begin
            repeat (100) @(posedge clk);
            #1;
            do_reset();
         end
      join
      check_state("t1");

      send_frame(16'hA5A5, 16'h1234, 16, 2, 1'b0);
      check_state("t2");
      read_n(1);
      check_state("t2_pop");

      send_frame(16'($urandom), 16'($urandom), 10, 0, 1'b0);
      send_frame(16'h0001, 16'hFFFF, 16, 0, 1'b0);
      check_state("t4");
      read_n(1);

      @(posedge clk);
      #1 bus.fifo_read = 1'b1;
      send_frame(16'($urandom), 16'($urandom), 16, 2, 1'b0);
      bus.fifo_read = 1'b0;
      check_state("t5");

      for (int f = 0; f < 9; f++) send_frame(16'($urandom), 16'($urandom), 16, 0, 1'b0);
      check_state("t3_full");
      read_n(8);
      check_state("t3_drain");

      do_reset();
      idle();
      for (int f = 0; f < 8; f++) send_frame(16'($urandom), 16'($urandom), 16, 0, 1'b0);
      send_frame(16'($urandom), 16'($urandom), 16, 1, 1'b0);
      check_state("t6_full");
      read_n(8);
      check_state("t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
